// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Purpose  : Shared types and constants for the EX/MEM memory access sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ABORT  = 2'd3
    } state_e;

    // Bit positions inside the 3-bit EX/MEM control field
    localparam int MEMWRITE_BIT = 2;
    localparam int MEMTOREG_BIT = 1;
    localparam int REGWRITE_BIT = 0;

    localparam int DEFAULT_TIMEOUT_CYCLES = 15;
    localparam int DEFAULT_CNT_W          = 4;

endpackage
`default_nettype wire

// File: rtl/mem_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : mem_timeout_counter
// Purpose  : Counts ACCESS cycles and flags the last cycle before a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_timeout_counter
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VALUE = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal count is true during the final allowed ACCESS cycle
    assign tc_o = (count_q == TC_VALUE);

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Stalls EX/MEM around a req/ack data memory access, bubbling MEM/WB.
//            Optional stall counter enabled by MEM_ACCESS_CTRL_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write_in,
    input  logic        mem_read_in,
    input  logic        flush_in,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        exmem_hold,
    output logic        memwb_bubble,
    output logic        load_data_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic [31:0] stall_cycles
);

    state_e state_q, state_d;
    logic   mem_req_q, mem_req_d;
    logic   mem_we_q, mem_we_d;
    logic   is_load_q, is_load_d;
    logic   timeout_err_q, timeout_err_d;
    logic   cnt_clear;
    logic   cnt_en;
    logic   cnt_tc;
    logic   memop;

    assign memop = mem_read_in | mem_write_in;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout_counter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .tc_o    (cnt_tc)
    );

    always_comb begin
        state_d         = state_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        is_load_d       = is_load_q;
        timeout_err_d   = timeout_err_q;
        exmem_hold      = 1'b0;
        memwb_bubble    = 1'b0;
        load_data_valid = 1'b0;
        cnt_clear       = 1'b0;
        cnt_en          = 1'b0;

        case (state_q)
            IDLE: begin
                if (memop) begin
                    memwb_bubble = 1'b1;
                    if (!flush_in) begin
                        exmem_hold = 1'b1;
                        state_d    = ACCESS;
                        mem_req_d  = 1'b1;
                        mem_we_d   = mem_write_in;
                        // Store wins when both control bits are set
                        is_load_d  = !mem_write_in;
                        cnt_clear  = 1'b1;
                    end
                end
            end
            ACCESS: begin
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
                cnt_en       = 1'b1;
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else if (cnt_tc) begin
                    state_d       = ABORT;
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    timeout_err_d = 1'b1;
                end
            end
            DONE: begin
                load_data_valid = is_load_q;
                state_d         = IDLE;
            end
            ABORT: begin
                memwb_bubble = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            is_load_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            is_load_q     <= is_load_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;

`ifdef MEM_ACCESS_CTRL_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (exmem_hold && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 32'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Randomized self-checking bench for mem_access_ctrl using a
//            per-transaction timeline model (honours MEM_ACCESS_CTRL_PERF_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write_in;
    logic        mem_read_in;
    logic        flush_in;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        exmem_hold;
    logic        memwb_bubble;
    logic        load_data_valid;
    logic        busy;
    logic        timeout_err;
    logic [31:0] stall_cycles;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        model_terr;
    logic [31:0] model_stall;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_write_in    (mem_write_in),
        .mem_read_in     (mem_read_in),
        .flush_in        (flush_in),
        .mem_ack         (mem_ack),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .exmem_hold      (exmem_hold),
        .memwb_bubble    (memwb_bubble),
        .load_data_valid (load_data_valid),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_stall();
`ifdef MEM_ACCESS_CTRL_PERF_EN
        return model_stall;
`else
        return 32'd0;
`endif
    endfunction

    // Apply inputs mid-low-phase, then settle before sampling
    task automatic drive(input logic r, input logic w, input logic f, input logic a);
        @(negedge clk);
        mem_read_in  = r;
        mem_write_in = w;
        flush_in     = f;
        mem_ack      = a;
        #1;
    endtask

    task automatic expect_cycle(input string tag, input logic e_hold, input logic e_bub,
                                input logic e_ldv, input logic e_req, input logic e_busy,
                                input logic e_we);
        check({tag, ".hold"},   {31'd0, exmem_hold},      {31'd0, e_hold});
        check({tag, ".bubble"}, {31'd0, memwb_bubble},    {31'd0, e_bub});
        check({tag, ".ldv"},    {31'd0, load_data_valid}, {31'd0, e_ldv});
        check({tag, ".req"},    {31'd0, mem_req},         {31'd0, e_req});
        check({tag, ".busy"},   {31'd0, busy},            {31'd0, e_busy});
        if (e_req) check({tag, ".we"}, {31'd0, mem_we}, {31'd0, e_we});
        check({tag, ".terr"},   {31'd0, timeout_err},     {31'd0, model_terr});
        check({tag, ".stall"},  stall_cycles,             exp_stall());
        if (e_hold && model_stall != 32'hFFFF_FFFF) model_stall++;
    endtask

    task automatic run_nonmem();
        drive(1'b0, 1'b0, 1'($urandom), 1'($urandom));
        expect_cycle("nonmem", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_flushed(input logic is_store);
        drive(is_store ? 1'($urandom) : 1'b1, is_store, 1'b1, 1'($urandom));
        expect_cycle("flush", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ack_at = ACCESS cycle (1-based) on which ack arrives; 0 = never
    task automatic run_memop(input logic is_store, input int ack_at);
        int n;
        n = (ack_at == 0) ? TO : ack_at;
        drive(is_store ? 1'($urandom) : 1'b1, is_store, 1'b0, 1'($urandom));
        expect_cycle("detect", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= n; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), (i == ack_at));
            expect_cycle("access", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, is_store);
        end
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        if (ack_at == 0) begin
            model_terr = 1'b1;
            expect_cycle("abort", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end else begin
            expect_cycle("done", 1'b0, 1'b0, !is_store, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        flush_in     = 1'b0;
        mem_ack      = 1'b0;
        model_terr   = 1'b0;
        model_stall  = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst.req",   {31'd0, mem_req},     32'd0);
        check("rst.we",    {31'd0, mem_we},      32'd0);
        check("rst.busy",  {31'd0, busy},        32'd0);
        check("rst.terr",  {31'd0, timeout_err}, 32'd0);
        check("rst.stall", stall_cycles,         32'd0);
        reset = 1'b0;

        repeat (10) run_nonmem();
        run_memop(1'b0, 3);
        run_memop(1'b1, 1);
        run_memop(1'b1, 1);
        run_memop(1'b0, 0);
        run_memop(1'b1, 2);
        run_flushed(1'b1);
        run_flushed(1'b0);
        run_memop(1'b0, TO);

        // Asynchronous reset while an access is outstanding
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_cycle("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_rst.req", {31'd0, mem_req}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("arst.req",   {31'd0, mem_req},     32'd0);
        check("arst.busy",  {31'd0, busy},        32'd0);
        check("arst.terr",  {31'd0, timeout_err}, 32'd0);
        check("arst.stall", stall_cycles,         32'd0);
        model_terr  = 1'b0;
        model_stall = 32'd0;
        @(negedge clk);
        reset = 1'b0;

        for (int t = 0; t < 120; t++) begin
            int kind;
            int ack_at;
            kind   = int'($urandom_range(9, 0));
            ack_at = (kind == 9) ? 0 : int'($urandom_range(TO, 1));
            if (kind < 3)       run_nonmem();
            else if (kind == 3) run_flushed(1'($urandom));
            else                run_memop(1'($urandom), ack_at);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
